// File: rtl/bydin_pkg.sv
// Shared definitions for the byte-deinterleaver read path: FSM encoding,
// frame geometry and default sizing.
package bydin_pkg;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        READ  = 2'd1,
        DRAIN = 2'd2
    } rd_state_t;

    localparam int unsigned FRAME_ROWS     = 72;
    localparam int unsigned FRAME_COLS     = 224;
    localparam int unsigned FRAME_LEN_DEF  = FRAME_ROWS * FRAME_COLS;
    localparam int unsigned RD_LAT_DEF     = 4;
    localparam int unsigned FIFO_DEPTH_DEF = 16;
    localparam int unsigned CNT_W_DEF      = 14;

endpackage

// File: rtl/bydin_sync_fifo.sv
// Synchronous first-word-fall-through FIFO; push while full is accepted only
// when a pop frees the slot in the same cycle.
module bydin_sync_fifo #(
    parameter int unsigned WIDTH = 8,
    parameter int unsigned DEPTH = 16
) (
    input  logic                     clk,
    input  logic                     reset,
    input  logic                     push,
    input  logic [WIDTH-1:0]         push_data,
    input  logic                     pop,
    output logic [WIDTH-1:0]         pop_data,
    output logic [$clog2(DEPTH):0]   count,
    output logic                     full,
    output logic                     empty
);

    localparam int unsigned AW = $clog2(DEPTH);

    logic [WIDTH-1:0] mem [DEPTH];
    logic [AW-1:0]    wr_ptr;
    logic [AW-1:0]    rd_ptr;
    logic             do_push;
    logic             do_pop;

    assign empty    = (count == '0);
    assign full     = (count == (AW+1)'(DEPTH));
    assign do_pop   = pop & ~empty;
    assign do_push  = push & (~full | do_pop);
    assign pop_data = empty ? '0 : mem[rd_ptr];

    always_ff @(posedge clk) begin
        if (do_push)
            mem[wr_ptr] <= push_data;
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            count  <= '0;
        end else begin
            if (do_push)
                wr_ptr <= wr_ptr + 1'b1;
            if (do_pop)
                rd_ptr <= rd_ptr + 1'b1;
            case ({do_push, do_pop})
                2'b10:   count <= count + 1'b1;
                2'b01:   count <= count - 1'b1;
                default: ;
            endcase
        end
    end

endmodule

// File: rtl/bydin_rd_ctrl.sv
// Frame read sequencer: issues FRAME_LEN read strobes per frame interrupt,
// credit-limited so returned bytes always fit in the output FIFO.
module bydin_rd_ctrl
    import bydin_pkg::*;
#(
    parameter int unsigned FRAME_LEN  = FRAME_LEN_DEF,
    parameter int unsigned RD_LAT     = RD_LAT_DEF,
    parameter int unsigned FIFO_DEPTH = FIFO_DEPTH_DEF,
    parameter int unsigned CNT_W      = CNT_W_DEF
) (
    input  logic       clk,
    input  logic       reset,
    input  logic       ctrl_enable,
    input  logic       bydin_int,
    output logic       mem_rd_ena,
    input  logic [7:0] mem_data_in,
    input  logic       mem_ena_in,
    output logic [7:0] spi_data,
    output logic       spi_valid,
    input  logic       spi_ready,
    output logic       frame_start,
    output logic       frame_done,
    output logic       busy,
    output logic       int_miss,
    output logic       proto_err
);

    localparam int unsigned CW = $clog2(FIFO_DEPTH) + 1;

    if ((FIFO_DEPTH < RD_LAT + 1) || ((FIFO_DEPTH & (FIFO_DEPTH - 1)) != 0) ||
        ((2 ** CNT_W) <= FRAME_LEN) || (FRAME_LEN < 1)) begin : g_param_check
        $error("bydin_rd_ctrl: illegal FRAME_LEN/RD_LAT/FIFO_DEPTH/CNT_W combination");
    end

    rd_state_t        state;
    logic             int_prev;
    logic             int_edge;
    logic [CNT_W-1:0] issue_left;
    logic [CNT_W-1:0] pop_cnt;
    logic [CW-1:0]    outstanding;
    logic [CW-1:0]    fifo_count;
    logic [CW:0]      credit_used;
    logic             fifo_full;
    logic             fifo_empty;
    logic             pop;
    logic             ret_ok;
    logic             ret_orphan;
    logic             push_overflow;

    bydin_sync_fifo #(
        .WIDTH (8),
        .DEPTH (FIFO_DEPTH)
    ) u_fifo (
        .clk       (clk),
        .reset     (reset),
        .push      (mem_ena_in),
        .push_data (mem_data_in),
        .pop       (pop),
        .pop_data  (spi_data),
        .count     (fifo_count),
        .full      (fifo_full),
        .empty     (fifo_empty)
    );

    assign int_edge      = bydin_int & ~int_prev;
    assign spi_valid     = ~fifo_empty;
    assign pop           = spi_valid & spi_ready;
    // Bytes in the FIFO plus bytes still in flight must never exceed its depth.
    assign credit_used   = {1'b0, fifo_count} + {1'b0, outstanding};
    assign mem_rd_ena    = (state == READ) && (issue_left != '0) &&
                           (credit_used < (CW+1)'(FIFO_DEPTH));
    assign frame_done    = pop && (state != IDLE) && (pop_cnt == CNT_W'(FRAME_LEN - 1));
    assign ret_ok        = mem_ena_in && (outstanding != '0);
    assign ret_orphan    = mem_ena_in && (outstanding == '0);
    assign push_overflow = mem_ena_in && fifo_full && ~pop;

    always_ff @(posedge clk) begin
        if (reset) begin
            state       <= IDLE;
            int_prev    <= 1'b0;
            issue_left  <= '0;
            pop_cnt     <= '0;
            outstanding <= '0;
            frame_start <= 1'b0;
            busy        <= 1'b0;
            int_miss    <= 1'b0;
            proto_err   <= 1'b0;
        end else begin
            int_prev    <= bydin_int;
            frame_start <= 1'b0;

            if (pop)
                pop_cnt <= pop_cnt + 1'b1;

            case ({mem_rd_ena, ret_ok})
                2'b10:   outstanding <= outstanding + 1'b1;
                2'b01:   outstanding <= outstanding - 1'b1;
                default: ;
            endcase

            if (ret_orphan || push_overflow)
                proto_err <= 1'b1;
            if (int_edge && busy)
                int_miss <= 1'b1;

            case (state)
                IDLE: begin
                    if (int_edge && ctrl_enable) begin
                        state       <= READ;
                        frame_start <= 1'b1;
                        busy        <= 1'b1;
                        issue_left  <= CNT_W'(FRAME_LEN);
                        pop_cnt     <= '0;
                    end
                end
                READ: begin
                    if (mem_rd_ena) begin
                        issue_left <= issue_left - 1'b1;
                        if (issue_left == CNT_W'(1))
                            state <= DRAIN;
                    end
                end
                DRAIN: begin
                    // Leave on the final pop so busy drops the cycle after frame_done.
                    if (frame_done || ((pop_cnt == CNT_W'(FRAME_LEN)) &&
                                       (outstanding == '0) && fifo_empty)) begin
                        state <= IDLE;
                        busy  <= 1'b0;
                    end
                end
                default: state <= IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_bydin_rd_ctrl.sv
// Self-checking bench: a short-frame instance for directed scenarios and a
// full-size instance for a long randomized-backpressure frame.
module tb_bydin_rd_ctrl;

    localparam int RD_LAT = 4;
    localparam int FL0    = 40;
    localparam int FL1    = 16128;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    int cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    int n_tests = 0;
    int n_fail  = 0;
    int edge_cyc;

    logic       rst     [2];
    logic       ctrl_en [2];
    logic       bint    [2];
    logic       spi_rdy [2];
    logic       inj     [2];
    logic       rd_ena  [2];
    logic       svalid  [2];
    logic       fstart  [2];
    logic       fdone   [2];
    logic       busy    [2];
    logic       imiss   [2];
    logic       perr    [2];
    logic [7:0] sdata   [2];

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_tests++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0d expected %0d (cycle %0d)", tag, got, exp, cyc);
        end
    endtask

    // Memory contents: byte at sequential read address n.
    function automatic logic [7:0] mem_byte(input int n);
        return 8'(n * 37 + (n >> 8) * 11 + 5);
    endfunction

    for (genvar g = 0; g < 2; g++) begin : g_dut
        localparam int FL = (g == 0) ? FL0 : FL1;

        logic       pv [RD_LAT];
        logic [7:0] pd [RD_LAT];
        logic       pv_out = 1'b0;
        logic [7:0] pd_out = 8'h00;
        logic       mena;
        logic [7:0] mdata;
        int s_cnt, r_cnt, p_cnt, starts, dones, max_occ, max_outs;
        int first_s, last_s, start_cyc, done_cyc, fall_cyc;
        logic       busy_q, stall_q;
        logic [7:0] data_q;

        assign mena  = pv_out | inj[g];
        assign mdata = inj[g] ? 8'hA5 : pd_out;

        bydin_rd_ctrl #(
            .FRAME_LEN  (FL),
            .RD_LAT     (RD_LAT),
            .FIFO_DEPTH (16),
            .CNT_W      (14)
        ) u_dut (
            .clk         (clk),
            .reset       (rst[g]),
            .ctrl_enable (ctrl_en[g]),
            .bydin_int   (bint[g]),
            .mem_rd_ena  (rd_ena[g]),
            .mem_data_in (mdata),
            .mem_ena_in  (mena),
            .spi_data    (sdata[g]),
            .spi_valid   (svalid[g]),
            .spi_ready   (spi_rdy[g]),
            .frame_start (fstart[g]),
            .frame_done  (fdone[g]),
            .busy        (busy[g]),
            .int_miss    (imiss[g]),
            .proto_err   (perr[g])
        );

        always @(posedge clk) begin
            #1;
            pv_out = pv[RD_LAT-1];
            pd_out = pd[RD_LAT-1];
        end

        always @(negedge clk) begin
            if (rst[g]) begin
                for (int i = 0; i < RD_LAT; i++) begin
                    pv[i] = 1'b0;
                    pd[i] = 8'h00;
                end
                s_cnt = 0; r_cnt = 0; p_cnt = 0; starts = 0; dones = 0;
                max_occ = 0; max_outs = 0;
                first_s = -1; last_s = -1; start_cyc = -1; done_cyc = -1; fall_cyc = -1;
                busy_q = 1'b0; stall_q = 1'b0; data_q = 8'h00;
            end else begin
                for (int i = RD_LAT - 1; i > 0; i--) begin
                    pv[i] = pv[i-1];
                    pd[i] = pd[i-1];
                end
                pv[0] = rd_ena[g];
                pd[0] = mem_byte(s_cnt);
                if (rd_ena[g]) begin
                    if (first_s < 0) first_s = cyc;
                    last_s = cyc;
                    s_cnt++;
                end
                if (mena) r_cnt++;
                if (stall_q && svalid[g])
                    check("hold_data", sdata[g], data_q);
                if (svalid[g] && spi_rdy[g]) begin
                    check("pop_data", sdata[g], mem_byte(p_cnt));
                    check("done_on_last", fdone[g], 32'(((p_cnt + 1) % FL) == 0));
                    p_cnt++;
                end
                stall_q = svalid[g] & ~spi_rdy[g];
                data_q  = sdata[g];
                if (fstart[g]) begin
                    starts++;
                    start_cyc = cyc;
                    check("busy_at_start", busy[g], 1);
                end
                if (fdone[g]) begin
                    dones++;
                    done_cyc = cyc;
                end
                if (busy_q && !busy[g]) fall_cyc = cyc;
                busy_q = busy[g];
                if (r_cnt - p_cnt > max_occ)  max_occ  = r_cnt - p_cnt;
                if (s_cnt - r_cnt > max_outs) max_outs = s_cnt - r_cnt;
            end
        end
    end

    task automatic step(input int n);
        repeat (n) @(posedge clk);
        #1;
    endtask

    task automatic apply_reset(input int g);
        rst[g] = 1'b1; ctrl_en[g] = 1'b1; bint[g] = 1'b0; spi_rdy[g] = 1'b0; inj[g] = 1'b0;
        step(3);
        rst[g] = 1'b0;
        step(1);
    endtask

    task automatic pulse_int(input int g, input int hi);
        bint[g] = 1'b1;
        edge_cyc = cyc;
        step(hi);
        bint[g] = 1'b0;
    endtask

    task automatic wait_done0(input int target, input int budget);
        for (int i = 0; i < budget && g_dut[0].dones < target; i++) step(1);
        check("wait_done", g_dut[0].dones, target);
    endtask

    initial begin
        for (int g = 0; g < 2; g++) begin
            rst[g] = 1'b1; ctrl_en[g] = 1'b1; bint[g] = 1'b0; spi_rdy[g] = 1'b0; inj[g] = 1'b0;
        end

        // Reset state, then a frame with the consumer always ready.
        step(3);
        check("rst_rd_ena", rd_ena[0], 0);
        check("rst_valid",  svalid[0], 0);
        check("rst_data",   sdata[0],  0);
        check("rst_busy",   busy[0],   0);
        check("rst_start",  fstart[0], 0);
        check("rst_done",   fdone[0],  0);
        check("rst_miss",   imiss[0],  0);
        check("rst_perr",   perr[0],   0);
        rst[0] = 1'b0;
        step(1);
        spi_rdy[0] = 1'b1;
        pulse_int(0, 16);
        wait_done0(1, 300);
        step(3);
        check("t1_starts",      g_dut[0].starts, 1);
        check("t1_strobes",     g_dut[0].s_cnt, FL0);
        check("t1_pops",        g_dut[0].p_cnt, FL0);
        check("t1_consecutive", g_dut[0].last_s - g_dut[0].first_s, FL0 - 1);
        check("t1_first_strobe", g_dut[0].first_s, g_dut[0].start_cyc);
        check("t1_start_lat",   g_dut[0].start_cyc - edge_cyc, 1);
        check("t1_busy_fall",   g_dut[0].fall_cyc, g_dut[0].done_cyc + 1);
        check("t1_frame_time",  g_dut[0].fall_cyc - edge_cyc, FL0 + RD_LAT + 2);
        check("t1_max_outs",    g_dut[0].max_outs, RD_LAT);
        check("t1_miss",        imiss[0], 0);
        check("t1_perr",        perr[0], 0);

        // Consumer stalled: issue must stop once FIFO plus in-flight reach 16.
        apply_reset(0);
        pulse_int(0, 16);
        step(34);
        check("t2_strobes_stalled", g_dut[0].s_cnt, 16);
        check("t2_occ_full",        g_dut[0].max_occ, 16);
        check("t2_valid",           svalid[0], 1);
        check("t2_busy",            busy[0], 1);
        check("t2_perr",            perr[0], 0);
        spi_rdy[0] = 1'b1;
        wait_done0(1, 300);
        step(2);
        check("t2_strobes", g_dut[0].s_cnt, FL0);
        check("t2_pops",    g_dut[0].p_cnt, FL0);
        check("t2_perr_end", perr[0], 0);
        check("t2_busy_end", busy[0], 0);

        // Second interrupt edge while busy; ctrl_enable dropped mid-frame.
        apply_reset(0);
        spi_rdy[0] = 1'b1;
        pulse_int(0, 4);
        check("t3_miss_before", imiss[0], 0);
        ctrl_en[0] = 1'b0;
        step(3);
        bint[0] = 1'b1;
        step(4);
        bint[0] = 1'b0;
        check("t3_miss_set", imiss[0], 1);
        wait_done0(1, 300);
        step(3);
        check("t3_starts",  g_dut[0].starts, 1);
        check("t3_strobes", g_dut[0].s_cnt, FL0);
        check("t3_pops",    g_dut[0].p_cnt, FL0);
        check("t3_miss_sticky", imiss[0], 1);

        // Return with nothing outstanding.
        apply_reset(0);
        step(2);
        inj[0] = 1'b1;
        step(1);
        inj[0] = 1'b0;
        step(1);
        check("t4_perr",  perr[0], 1);
        check("t4_valid", svalid[0], 1);
        step(5);
        check("t4_perr_sticky", perr[0], 1);
        apply_reset(0);
        check("t4_perr_clr",  perr[0], 0);
        check("t4_valid_clr", svalid[0], 0);
        check("t4_busy_clr",  busy[0], 0);
        check("t4_idle",      rd_ena[0], 0);

        // Disabled interrupt, enable while level high, then a fresh edge.
        apply_reset(0);
        ctrl_en[0] = 1'b0;
        spi_rdy[0] = 1'b1;
        bint[0] = 1'b1;
        step(6);
        check("t5_no_strobe", g_dut[0].s_cnt, 0);
        check("t5_no_busy",   busy[0], 0);
        ctrl_en[0] = 1'b1;
        step(6);
        check("t5_level_no_start", g_dut[0].starts, 0);
        bint[0] = 1'b0;
        step(2);
        pulse_int(0, 3);
        wait_done0(1, 300);
        check("t5_starts", g_dut[0].starts, 1);
        check("t5_pops",   g_dut[0].p_cnt, FL0);

        // Full-size frame with the consumer ready about 30% of cycles.
        apply_reset(1);
        bint[1] = 1'b1;
        for (int i = 0; i < 70000 && g_dut[1].dones < 1; i++) begin
            spi_rdy[1] = ($urandom_range(0, 99) < 30);
            if (i == 10) bint[1] = 1'b0;
            step(1);
        end
        spi_rdy[1] = 1'b0;
        check("t6_done",     g_dut[1].dones, 1);
        step(2);
        check("t6_starts",   g_dut[1].starts, 1);
        check("t6_strobes",  g_dut[1].s_cnt, FL1);
        check("t6_pops",     g_dut[1].p_cnt, FL1);
        check("t6_max_occ",  g_dut[1].max_occ, 16);
        check("t6_max_outs", g_dut[1].max_outs, RD_LAT);
        check("t6_perr",     perr[1], 0);
        check("t6_busy_end", busy[1], 0);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
